// File: rtl/pio_shift_pkg.sv
// rtl/pio_shift_pkg.sv - shared state encodings, defaults and bit-order helpers for the PIO shift-out block
// Contents: state_t FSM encoding, CLK_DIV_DEFAULT, lead_bit() and advance() shift helpers.
package pio_shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_LO = 2'd1,
        ST_SHIFT_HI = 2'd2,
        ST_LATCH    = 2'd3
    } state_t;

    localparam int CLK_DIV_DEFAULT = 4;

    // Bit presented on sr_data for the current shift-register contents.
    function automatic logic lead_bit(input logic [7:0] v, input bit msb_first);
        return msb_first ? v[7] : v[0];
    endfunction

    // Shift-register contents after one bit has been sent.
    function automatic logic [7:0] advance(input logic [7:0] v, input bit msb_first);
        return msb_first ? {v[6:0], 1'b0} : {1'b0, v[7:1]};
    endfunction

endpackage

// File: rtl/pio_shift_out_if.sv
// rtl/pio_shift_out_if.sv - PIO-side inputs and 74HC595-side serial outputs of the shift-out block
// Signals: data_in[7:0], refresh (PIO -> block); sr_data, sr_clk, sr_latch, busy (block -> outside).
// Modports: master = stimulus/PIO side, slave = pio_shift_out.
interface pio_shift_out_if;
    logic [7:0] data_in;
    logic       refresh;
    logic       sr_data;
    logic       sr_clk;
    logic       sr_latch;
    logic       busy;

    modport master (
        output data_in,
        output refresh,
        input  sr_data,
        input  sr_clk,
        input  sr_latch,
        input  busy
    );

    modport slave (
        input  data_in,
        input  refresh,
        output sr_data,
        output sr_clk,
        output sr_latch,
        output busy
    );
endinterface

// File: rtl/pio_shift_tick.sv
// rtl/pio_shift_tick.sv - divider producing a one-cycle tick every CLK_DIV cycles while enabled
// Ports: clk, reset_n (sync, active-low), enable (count while high, clear while low), tick (pulse output).
module pio_shift_tick #(
    parameter int CLK_DIV = pio_shift_pkg::CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);
    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    // Wrapping to 0 on LAST lets consecutive states each last exactly CLK_DIV
    // cycles without any explicit restart from the FSM.
    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tick = enable && (cnt == LAST);
endmodule

// File: rtl/pio_shift_out.sv
// rtl/pio_shift_out.sv - serialises an 8-bit PIO value into a 74HC595-style shift/latch register
// Ports: clk, reset_n (sync, active-low), bus (pio_shift_out_if.slave: data_in, refresh in;
//        sr_data, sr_clk, sr_latch, busy out, all registered).
// Parameters: CLK_DIV (system clocks per sr_clk half-period, 1..255), MSB_FIRST (1: bit 7 first).
module pio_shift_out
    import pio_shift_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_shift_out_if.slave   bus
);
    state_t     state;
    logic [7:0] shreg;
    logic [7:0] sent_val;
    logic [7:0] last_sent;
    logic [2:0] bit_cnt;
    logic       init_pending;
    logic       tick;
    logic       div_en;
    logic       start;
    logic [7:0] shreg_adv;

    // Divider runs only during a transfer, so it is already 0 on the start cycle.
    assign div_en    = (state != ST_IDLE);
    assign start     = (bus.data_in != last_sent) || bus.refresh || init_pending;
    assign shreg_adv = advance(shreg, MSB_FIRST);

    pio_shift_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (div_en),
        .tick    (tick)
    );

    // sent_val keeps the captured byte intact while shreg is consumed, so the
    // change detector compares against what was actually latched.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            shreg        <= '0;
            sent_val     <= '0;
            last_sent    <= '0;
            bit_cnt      <= '0;
            init_pending <= 1'b1;
            bus.sr_data  <= 1'b0;
            bus.sr_clk   <= 1'b0;
            bus.sr_latch <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg       <= bus.data_in;
                        sent_val    <= bus.data_in;
                        bit_cnt     <= '0;
                        bus.sr_data <= lead_bit(bus.data_in, MSB_FIRST);
                        bus.sr_clk  <= 1'b0;
                        bus.busy    <= 1'b1;
                        state       <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (tick) begin
                        bus.sr_clk <= 1'b1;
                        state      <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tick) begin
                        bus.sr_clk <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            bus.sr_latch <= 1'b1;
                            state        <= ST_LATCH;
                        end else begin
                            shreg       <= shreg_adv;
                            bit_cnt     <= bit_cnt + 3'd1;
                            bus.sr_data <= lead_bit(shreg_adv, MSB_FIRST);
                            state       <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_LATCH: begin
                    if (tick) begin
                        bus.sr_latch <= 1'b0;
                        bus.sr_data  <= 1'b0;
                        bus.busy     <= 1'b0;
                        last_sent    <= sent_val;
                        init_pending <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pio_shift_out.sv
// tb/tb_pio_shift_out.sv - self-checking bench for pio_shift_out with a 74HC595 model and latch scoreboard
module tb_pio_shift_out;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pio_shift_out_if a_if ();
    pio_shift_out_if b_if ();
    pio_shift_out_if c_if ();

    pio_shift_out #(.CLK_DIV(4), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(a_if));
    pio_shift_out #(.CLK_DIV(4), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .reset_n(reset_n), .bus(b_if));
    pio_shift_out #(.CLK_DIV(1), .MSB_FIRST(1'b1)) dut_c (.clk(clk), .reset_n(reset_n), .bus(c_if));

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    logic [2:0] w_clk, w_data, w_latch, w_busy;
    logic [2:0] p_clk, p_latch, p_busy;
    assign w_clk   = {c_if.sr_clk,   b_if.sr_clk,   a_if.sr_clk};
    assign w_data  = {c_if.sr_data,  b_if.sr_data,  a_if.sr_data};
    assign w_latch = {c_if.sr_latch, b_if.sr_latch, a_if.sr_latch};
    assign w_busy  = {c_if.busy,     b_if.busy,     a_if.busy};

    // External register model per DUT: shift on sr_clk rise, capture on sr_latch rise.
    logic [7:0] model [3];
    logic       bits [3][64];
    logic [7:0] latched [3][16];
    int bit_n [3];
    int lat_n [3];
    int lrun [3];
    int llen [3];
    int brun [3];
    int blen [3];
    int grun [3];
    int gap [3];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (w_clk[d] && !p_clk[d]) begin
                if (bit_n[d] < 64) bits[d][bit_n[d]] = w_data[d];
                bit_n[d]++;
                if (d == 1) model[d] = {w_data[d], model[d][7:1]};
                else        model[d] = {model[d][6:0], w_data[d]};
            end
            if (w_latch[d] && !p_latch[d]) begin
                if (lat_n[d] < 16) latched[d][lat_n[d]] = model[d];
                lat_n[d]++;
            end
            if (w_latch[d]) lrun[d]++;
            else begin
                if (p_latch[d]) llen[d] = lrun[d];
                lrun[d] = 0;
            end
            if (w_busy[d]) begin
                if (!p_busy[d]) gap[d] = grun[d];
                brun[d]++;
                grun[d] = 0;
            end else begin
                if (p_busy[d]) blen[d] = brun[d];
                brun[d] = 0;
                grun[d]++;
            end
        end
        p_clk   = w_clk;
        p_latch = w_latch;
        p_busy  = w_busy;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        for (int d = 0; d < 3; d++) begin
            model[d] = 8'h00; bit_n[d] = 0; lat_n[d] = 0; lrun[d] = 0; llen[d] = 0;
            brun[d] = 0; blen[d] = 0; grun[d] = 0; gap[d] = -1;
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        a_if.data_in = 8'h00; a_if.refresh = 1'b0;
        b_if.data_in = 8'h00; b_if.refresh = 1'b0;
        c_if.data_in = 8'h00; c_if.refresh = 1'b0;
        p_clk = '0; p_latch = '0; p_busy = '0;
        clear_mon();
        step(3);
        n_checks++; if (a_if.sr_data !== 1'b0)  begin n_fail++; $display("FAIL reset_sr_data got=%b exp=0", a_if.sr_data); end
        n_checks++; if (a_if.sr_clk !== 1'b0)   begin n_fail++; $display("FAIL reset_sr_clk got=%b exp=0", a_if.sr_clk); end
        n_checks++; if (a_if.sr_latch !== 1'b0) begin n_fail++; $display("FAIL reset_sr_latch got=%b exp=0", a_if.sr_latch); end
        n_checks++; if (w_busy !== 3'b000)      begin n_fail++; $display("FAIL reset_busy got=%b exp=000", w_busy); end
    endtask

    task automatic test_init();
        clear_mon();
        exp_q.push_back(8'h00);
        reset_n = 1'b1;
        step(1);
        n_checks++; if (a_if.busy !== 1'b1) begin n_fail++; $display("FAIL init_start_latency busy=%b exp=1", a_if.busy); end
        step(150);
        n_checks++; if (lat_n[0] !== 1) begin n_fail++; $display("FAIL init_latch_count got=%0d exp=1", lat_n[0]); end
        for (int i = 0; i < lat_n[0] && i < 16; i++) begin
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (latched[0][i] !== exp_v) begin n_fail++; $display("FAIL init_value got=%h exp=%h", latched[0][i], exp_v); end
        end
        n_checks++; if (blen[0] !== 68) begin n_fail++; $display("FAIL init_busy_len got=%0d exp=68", blen[0]); end
        n_checks++; if (llen[0] !== 4)  begin n_fail++; $display("FAIL init_latch_len got=%0d exp=4", llen[0]); end
        step(100);
        n_checks++; if (lat_n[0] !== 1) begin n_fail++; $display("FAIL init_no_repeat got=%0d exp=1", lat_n[0]); end
        n_checks++; if ({a_if.busy, a_if.sr_clk, a_if.sr_latch, a_if.sr_data} !== 4'b0000) begin
            n_fail++; $display("FAIL idle_outputs got=%b exp=0000", {a_if.busy, a_if.sr_clk, a_if.sr_latch, a_if.sr_data});
        end
    endtask

    task automatic test_msb_a5();
        logic [7:0] seq;
        clear_mon();
        a_if.data_in = 8'hA5;
        exp_q.push_back(8'hA5);
        step(150);
        seq = 8'h00;
        for (int i = 0; i < 8; i++) seq = {seq[6:0], bits[0][i]};
        n_checks++; if (bit_n[0] !== 8) begin n_fail++; $display("FAIL a5_bit_count got=%0d exp=8", bit_n[0]); end
        n_checks++; if (seq !== 8'hA5) begin n_fail++; $display("FAIL a5_bit_order got=%h exp=a5", seq); end
        n_checks++; if (llen[0] !== 4) begin n_fail++; $display("FAIL a5_latch_len got=%0d exp=4", llen[0]); end
        n_checks++; if (lat_n[0] !== 1) begin n_fail++; $display("FAIL a5_latch_count got=%0d exp=1", lat_n[0]); end
        for (int i = 0; i < lat_n[0] && i < 16; i++) begin
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (latched[0][i] !== exp_v) begin n_fail++; $display("FAIL a5_value got=%h exp=%h", latched[0][i], exp_v); end
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] seq;
        clear_mon();
        b_if.data_in = 8'h01;
        exp_q.push_back(8'h01);
        step(150);
        seq = 8'h00;
        for (int i = 0; i < 8; i++) seq = {seq[6:0], bits[1][i]};
        n_checks++; if (seq !== 8'h80) begin n_fail++; $display("FAIL lsb_bit_seq got=%h exp=80", seq); end
        n_checks++; if (lat_n[1] !== 1) begin n_fail++; $display("FAIL lsb_latch_count got=%0d exp=1", lat_n[1]); end
        for (int i = 0; i < lat_n[1] && i < 16; i++) begin
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (latched[1][i] !== exp_v) begin n_fail++; $display("FAIL lsb_value got=%h exp=%h", latched[1][i], exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        a_if.data_in = 8'h11; exp_q.push_back(8'h11);
        step(10);
        a_if.data_in = 8'h22;
        step(10);
        a_if.data_in = 8'h33; exp_q.push_back(8'h33);
        step(300);
        n_checks++; if (lat_n[0] !== 2) begin n_fail++; $display("FAIL b2b_latch_count got=%0d exp=2", lat_n[0]); end
        for (int i = 0; i < lat_n[0] && i < 16; i++) begin
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (latched[0][i] !== exp_v) begin n_fail++; $display("FAIL b2b_value[%0d] got=%h exp=%h", i, latched[0][i], exp_v); end
        end
        n_checks++; if (gap[0] !== 1) begin n_fail++; $display("FAIL b2b_idle_gap got=%0d exp=1", gap[0]); end
    endtask

    task automatic test_refresh();
        a_if.data_in = 8'h5A;
        step(150);
        clear_mon();
        a_if.refresh = 1'b1; exp_q.push_back(8'h5A);
        step(1);
        a_if.refresh = 1'b0;
        step(10);
        a_if.refresh = 1'b1;
        step(1);
        a_if.refresh = 1'b0;
        step(150);
        n_checks++; if (lat_n[0] !== 1) begin n_fail++; $display("FAIL refresh_latch_count got=%0d exp=1", lat_n[0]); end
        for (int i = 0; i < lat_n[0] && i < 16; i++) begin
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (latched[0][i] !== exp_v) begin n_fail++; $display("FAIL refresh_value got=%h exp=%h", latched[0][i], exp_v); end
        end
        n_checks++; if (blen[0] !== 68) begin n_fail++; $display("FAIL refresh_busy_len got=%0d exp=68", blen[0]); end
    endtask

    task automatic test_refresh_with_change();
        clear_mon();
        a_if.data_in = 8'h3C; a_if.refresh = 1'b1; exp_q.push_back(8'h3C);
        step(1);
        a_if.refresh = 1'b0;
        step(200);
        n_checks++; if (lat_n[0] !== 1) begin n_fail++; $display("FAIL refchg_latch_count got=%0d exp=1", lat_n[0]); end
        for (int i = 0; i < lat_n[0] && i < 16; i++) begin
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (latched[0][i] !== exp_v) begin n_fail++; $display("FAIL refchg_value got=%h exp=%h", latched[0][i], exp_v); end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        a_if.data_in = 8'hFF;
        step(30);
        reset_n = 1'b0;
        step(2);
        n_checks++; if ({a_if.busy, a_if.sr_clk, a_if.sr_latch, a_if.sr_data} !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_outputs got=%b exp=0000", {a_if.busy, a_if.sr_clk, a_if.sr_latch, a_if.sr_data});
        end
        n_checks++; if (lat_n[0] !== 0) begin n_fail++; $display("FAIL midrst_no_latch got=%0d exp=0", lat_n[0]); end
        reset_n = 1'b1;
        exp_q.push_back(8'hFF);
        step(150);
        n_checks++; if (lat_n[0] !== 1) begin n_fail++; $display("FAIL midrst_latch_count got=%0d exp=1", lat_n[0]); end
        for (int i = 0; i < lat_n[0] && i < 16; i++) begin
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (latched[0][i] !== exp_v) begin n_fail++; $display("FAIL midrst_value got=%h exp=%h", latched[0][i], exp_v); end
        end
        n_checks++; if (blen[0] !== 68) begin n_fail++; $display("FAIL midrst_busy_len got=%0d exp=68", blen[0]); end
    endtask

    task automatic test_clk_div1();
        clear_mon();
        c_if.data_in = 8'h96;
        exp_q.push_back(8'h96);
        step(60);
        n_checks++; if (blen[2] !== 17) begin n_fail++; $display("FAIL div1_busy_len got=%0d exp=17", blen[2]); end
        n_checks++; if (llen[2] !== 1)  begin n_fail++; $display("FAIL div1_latch_len got=%0d exp=1", llen[2]); end
        n_checks++; if (lat_n[2] !== 1) begin n_fail++; $display("FAIL div1_latch_count got=%0d exp=1", lat_n[2]); end
        for (int i = 0; i < lat_n[2] && i < 16; i++) begin
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (latched[2][i] !== exp_v) begin n_fail++; $display("FAIL div1_value got=%h exp=%h", latched[2][i], exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_msb_a5();
        test_lsb_first();
        test_back_to_back();
        test_refresh();
        test_refresh_with_change();
        test_reset_mid();
        test_clk_div1();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pio_shift_out.md
PIO_SHIFT_OUT -- requirements
Module: pio_shift_out

Interface
REQ-001 Parameter CLK_DIV, default 4: system-clock cycles per sr_clk half-period; legal range 1..255.
REQ-002 Parameter MSB_FIRST, default 1: 1 shifts bit 7 first, 0 shifts bit 0 first.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 data_in  input  8  parallel value, driven directly by the PIO out_port.
REQ-006 refresh  input  1  one-cycle pulse that forces a retransmit of data_in.
REQ-007 sr_data  output  1  serial data to an external 74HC595-style register.
REQ-008 sr_clk  output  1  shift clock; the external register samples on its rising edge.
REQ-009 sr_latch  output  1  storage-register latch pulse, active high.
REQ-010 busy  output  1  high from the transfer start cycle through the last LATCH cycle.

Function
REQ-011 States SHALL be IDLE, SHIFT_LO, SHIFT_HI, LATCH.
REQ-012 In IDLE, a start condition SHALL be any of: (data_in != last_sent), refresh == 1, or init_pending == 1.
- Start-cycle actions: data_in captured into an 8-bit shift register; bit counter cleared; divider cleared; next state SHIFT_LO.
REQ-013 SHIFT_LO behaviour:
- sr_clk = 0.
- sr_data = current bit, stable for the full CLK_DIV cycles.
- After CLK_DIV cycles, go to SHIFT_HI.
REQ-014 SHIFT_HI behaviour:
- sr_clk = 1; sr_data held unchanged.
- After CLK_DIV cycles: if 8 bits are done, go to LATCH; otherwise advance the shift register, increment the bit counter and go to SHIFT_LO.
REQ-015 LATCH behaviour:
- sr_clk = 0; sr_latch = 1 for CLK_DIV cycles.
- Then last_sent <= captured value, init_pending <= 0, state IDLE.
REQ-016 Transfer length SHALL be exactly 17*CLK_DIV cycles of busy=1, which is 68 cycles at default; start decision to first SHIFT_LO cycle = 1 cycle.
REQ-017 All of sr_data, sr_clk, sr_latch and busy SHALL be registered outputs with no combinational path from data_in.
REQ-018 Changes on data_in or refresh during a transfer SHALL be ignored by the active transfer and are not queued.
- On the first IDLE cycle, the comparison against last_sent is re-evaluated, so only the latest value is sent.
REQ-019 refresh asserted in the same cycle as a data_in change SHALL cause exactly one transfer.
REQ-020 Back-to-back transfers SHALL be separated by at least one IDLE cycle, with busy = 0 in that cycle.
REQ-021 In IDLE, outputs SHALL be: sr_clk = 0, sr_latch = 0, sr_data = 0, busy = 0.
REQ-022 The bit counter SHALL be 3 bits and the divider counter 8 bits; the divider wraps to 0 at CLK_DIV-1.

Reset
REQ-023 reset_n = 0, sampled on a rising clk edge, SHALL force:
- state IDLE; all counters 0; shift register 0; last_sent 0; init_pending 1.
- sr_data = 0, sr_clk = 0, sr_latch = 0, busy = 0, effective that edge.
REQ-024 Reset asserted mid-transfer SHALL abort it immediately with no latch pulse.
- The first IDLE cycle after reset release starts a full transfer of the current data_in, because init_pending = 1.
REQ-025 No asynchronous reset paths SHALL exist.

Structure
REQ-026 State encodings and the default CLK_DIV value SHALL live in the shared package pio_shift_pkg.
REQ-027 The divider SHALL be a separate sub-module, pio_shift_tick, that produces a one-cycle tick every CLK_DIV cycles while enabled and clears when disabled.
REQ-028 The FSM, shift register, bit counter and change detection SHALL reside in pio_shift_out.

Verification
REQ-029 Reset release with data_in=8'h00 -> one transfer of 0x00 (init), busy for 68 cycles, then idle with no further transfers.
REQ-030 data_in 8'h00 -> 8'hA5, MSB_FIRST=1 -> sr_data on successive sr_clk rises = 1,0,1,0,0,1,0,1; one 4-cycle sr_latch pulse; model register = 0xA5.
REQ-031 MSB_FIRST=0, data_in=8'h01 -> first sampled bit 1, remaining seven 0; latched value 0x01.
REQ-032 data_in changes 0x11 -> 0x22 -> 0x33 within one transfer -> exactly two transfers (0x11, then 0x33); 0x22 never latched.
REQ-033 refresh pulse with data_in unchanged at 0x5A -> one extra 68-cycle transfer of 0x5A; refresh during busy -> no extra transfer.
REQ-034 reset_n low at cycle 30 of a 0xFF transfer -> sr_latch never asserts for it; after release, a full 0xFF transfer completes; CLK_DIV=1 run -> busy lasts 17 cycles.
